vec_mul_accum: RTL and testbench



---
 rtl/vec_mul_pkg.sv | 27 ++
 rtl/vec_add_tree.sv | 33 +++
 rtl/vec_mul_accum.sv | 161 ++++++++++++++++
 tb/tb_vec_mul_accum.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_mul_pkg.sv
// Shared widths, saturation bounds and sizing helper for the vec_mul datapath.
// Latency: n/a (constants and functions only).
// Backpressure: n/a.
package vec_mul_pkg;

    localparam int DEF_LANES          = 8;
    localparam int DEF_PARTIAL_MUL_BW = 16;
    localparam int DEF_TILES          = 8;
    localparam int DEF_ACC_BW         = 24;

    // Smallest accumulator that can never wrap for the given shape.
    function automatic int min_acc_bw(input int partial_bw, input int lanes, input int tiles);
        return partial_bw + $clog2(lanes) + $clog2(tiles);
    endfunction

    function automatic logic signed [63:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    localparam logic signed [DEF_ACC_BW-1:0] DEF_SAT_MAX = DEF_ACC_BW'(sat_max(DEF_ACC_BW));
    localparam logic signed [DEF_ACC_BW-1:0] DEF_SAT_MIN = DEF_ACC_BW'(sat_min(DEF_ACC_BW));

endpackage

// File: rtl/vec_add_tree.sv
// Sign-extends LANES packed signed lanes to OUT_BW and sums them pairwise.
// Latency: combinational.
// Backpressure: none.
module vec_add_tree
    import vec_mul_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int IN_BW  = DEF_PARTIAL_MUL_BW,
    parameter int OUT_BW = DEF_ACC_BW
) (
    input  logic [LANES*IN_BW-1:0] lanes_vec,
    output logic signed [OUT_BW-1:0] sum
);

    localparam int LEVELS = $clog2(LANES);

    logic signed [OUT_BW-1:0] node [LANES];

    // Reduction happens in place: each level writes slot i from slots 2i and 2i+1,
    // which are never below i, so no operand is overwritten before it is read.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            node[i] = OUT_BW'(signed'(lanes_vec[i*IN_BW +: IN_BW]));
        end
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int i = 0; i < (LANES >> (lvl + 1)); i++) begin
                node[i] = node[2*i] + node[2*i+1];
            end
        end
        sum = node[0];
    end

endmodule

// File: rtl/vec_mul_accum.sv
// Reduces LANES signed partial products per beat and accumulates TILES beats per result.
// Latency: result valid 2 edges after the last beat of a tile; Backpressure: in_ready low while a result is held.
// Build option VEC_MUL_ACCUM_SATURATE_EN: clamp instead of wrap and report the clamp on out_sat.
module vec_mul_accum
    import vec_mul_pkg::*;
#(
    parameter int LANES          = DEF_LANES,
    parameter int PARTIAL_MUL_BW = DEF_PARTIAL_MUL_BW,
    parameter int TILES          = DEF_TILES,
    parameter int ACC_BW         = DEF_ACC_BW
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES*PARTIAL_MUL_BW-1:0]  partial_mul_vec,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [ACC_BW-1:0]         out_data,
    output logic                             out_sat,
    output logic                             busy
);

    localparam int CNT_BW = (TILES > 1) ? $clog2(TILES) : 1;
    localparam logic [CNT_BW-1:0] LAST_BEAT = CNT_BW'(TILES - 1);

`ifdef VEC_MUL_ACCUM_SATURATE_EN
    // The tree runs wide so an out-of-range beat can be clamped rather than wrapped.
    localparam int TREE_BW = ACC_BW + $clog2(LANES);
    localparam logic signed [ACC_BW-1:0]  SAT_MAX  = ACC_BW'(sat_max(ACC_BW));
    localparam logic signed [ACC_BW-1:0]  SAT_MIN  = ACC_BW'(sat_min(ACC_BW));
    localparam logic signed [TREE_BW-1:0] TREE_MAX = TREE_BW'(SAT_MAX);
    localparam logic signed [TREE_BW-1:0] TREE_MIN = TREE_BW'(SAT_MIN);
`else
    localparam int TREE_BW = ACC_BW;
`endif

    logic [CNT_BW-1:0]         beat_cnt;
    logic                      stall;
    logic                      accept;
    logic                      s2_fire;
    logic signed [TREE_BW-1:0] tree_sum;
    logic signed [ACC_BW-1:0]  beat_sum;
    logic signed [ACC_BW-1:0]  s1_sum;
    logic                      s1_valid;
    logic                      s1_first;
    logic                      s1_last;
    logic signed [ACC_BW-1:0]  acc;
    logic signed [ACC_BW-1:0]  acc_next;

    vec_add_tree #(
        .LANES  (LANES),
        .IN_BW  (PARTIAL_MUL_BW),
        .OUT_BW (TREE_BW)
    ) u_tree (
        .lanes_vec (partial_mul_vec),
        .sum       (tree_sum)
    );

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign s2_fire  = s1_valid && !stall;
    assign busy     = (beat_cnt != '0) || s1_valid;

`ifdef VEC_MUL_ACCUM_SATURATE_EN
    logic                    beat_clip;
    logic                    s1_clip;
    logic                    add_clip;
    logic                    sat_flag;
    logic                    sat_next;
    logic                    out_sat_q;
    logic signed [ACC_BW:0]  add_wide;

    always_comb begin
        beat_sum  = tree_sum[ACC_BW-1:0];
        beat_clip = 1'b0;
        if (tree_sum > TREE_MAX) begin
            beat_sum  = SAT_MAX;
            beat_clip = 1'b1;
        end else if (tree_sum < TREE_MIN) begin
            beat_sum  = SAT_MIN;
            beat_clip = 1'b1;
        end
    end

    // One guard bit: the top two bits disagree exactly when the sum left the range.
    always_comb begin
        add_wide = {acc[ACC_BW-1], acc} + {s1_sum[ACC_BW-1], s1_sum};
        add_clip = 1'b0;
        acc_next = add_wide[ACC_BW-1:0];
        if (s1_first) begin
            acc_next = s1_sum;
        end else if (add_wide[ACC_BW] != add_wide[ACC_BW-1]) begin
            add_clip = 1'b1;
            acc_next = add_wide[ACC_BW] ? SAT_MIN : SAT_MAX;
        end
        sat_next = s1_clip | add_clip | (!s1_first & sat_flag);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_clip   <= 1'b0;
            sat_flag  <= 1'b0;
            out_sat_q <= 1'b0;
        end else begin
            if (accept) begin
                s1_clip <= beat_clip;
            end
            if (s2_fire) begin
                sat_flag <= sat_next;
                if (s1_last) begin
                    out_sat_q <= sat_next;
                end
            end
        end
    end

    assign out_sat = out_sat_q;
`else
    assign beat_sum = tree_sum;
    assign acc_next = s1_first ? s1_sum : acc + s1_sum;
    assign out_sat  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
                s1_sum   <= beat_sum;
                s1_valid <= 1'b1;
                s1_first <= (beat_cnt == '0);
                s1_last  <= (beat_cnt == LAST_BEAT);
            end else if (!stall) begin
                s1_valid <= 1'b0;
            end

            if (s2_fire && !s1_last) begin
                acc <= acc_next;
            end

            // A fresh result overrides the clear so results can stream back-to-back.
            if (s2_fire && s1_last) begin
                out_data  <= acc_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vec_mul_accum.sv
// Directed bench for vec_mul_accum: a result-queue model checked every cycle on the default
// instance, plus small wrap/saturate (ACC_BW=18) and TILES=1 streaming instances.
module tb_vec_mul_accum;

    localparam int LANES = 8;
    localparam int PBW   = 16;
    localparam int W     = LANES * PBW;
    localparam int TILES = 8;
    localparam int ACC   = 24;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [W-1:0]          partial_mul_vec = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [ACC-1:0] out_data;
    logic                  out_sat;
    logic                  busy;

    logic                  w_valid = 1'b0;
    logic                  w_in_ready;
    logic [W-1:0]          w_vec = '0;
    logic                  w_out_valid;
    logic signed [17:0]    w_out_data;
    logic                  w_out_sat;
    logic                  w_busy;

    logic                  t_valid = 1'b0;
    logic                  t_in_ready;
    logic [W-1:0]          t_vec = '0;
    logic                  t_out_valid;
    logic signed [ACC-1:0] t_out_data;
    logic                  t_out_sat;
    logic                  t_busy;

    int     n_checks = 0;
    int     n_fail   = 0;
    bit     model_en = 1'b0;
    longint exp_q[$];
    longint part_sum = 0;
    int     part_n   = 0;
    int     cyc      = 0;
    bit     t_collect = 1'b0;
    longint t_vals[$];
    int     t_cycs[$];

    always #5 clk = ~clk;

    vec_mul_accum #(.LANES(LANES), .PARTIAL_MUL_BW(PBW), .TILES(TILES), .ACC_BW(ACC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .partial_mul_vec(partial_mul_vec), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .busy(busy));

    vec_mul_accum #(.LANES(LANES), .PARTIAL_MUL_BW(PBW), .TILES(8), .ACC_BW(18)) dut_w18 (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_in_ready),
        .partial_mul_vec(w_vec), .out_valid(w_out_valid), .out_ready(1'b1),
        .out_data(w_out_data), .out_sat(w_out_sat), .busy(w_busy));

    vec_mul_accum #(.LANES(LANES), .PARTIAL_MUL_BW(PBW), .TILES(1), .ACC_BW(ACC)) dut_t1 (
        .clk(clk), .rst(rst), .in_valid(t_valid), .in_ready(t_in_ready),
        .partial_mul_vec(t_vec), .out_valid(t_out_valid), .out_ready(1'b1),
        .out_data(t_out_data), .out_sat(t_out_sat), .busy(t_busy));

    task automatic check(input bit ok, input string nm, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rep(input int v);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*PBW +: PBW] = PBW'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] mix(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*PBW +: PBW] = PBW'((i - 4) * (k + 1));
        return r;
    endfunction

    function automatic logic [W-1:0] scatter(input int k);
        logic [W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*PBW +: PBW] = PBW'(((i * 37 + k * 11) % 200) - 100);
        return r;
    endfunction

    function automatic longint lane_sum(input logic [W-1:0] v);
        longint s = 0;
        for (int i = 0; i < LANES; i++) s += longint'($signed(v[i*PBW +: PBW]));
        return s;
    endfunction

    function automatic longint wrap_acc(input longint v);
        logic signed [ACC-1:0] t;
        t = v[ACC-1:0];
        return longint'(t);
    endfunction

    // Model: each completed group of TILES accepted beats yields one result, in order.
    always @(negedge clk) begin
        if (model_en) begin
            check(in_ready === !(out_valid && !out_ready), "in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                check(exp_q.size() > 0, "unexpected_result", out_data, 0);
                if (exp_q.size() > 0) begin
                    check(longint'(out_data) == exp_q[0], "model_data", out_data, exp_q[0]);
                    check(out_sat === 1'b0, "model_sat", out_sat, 0);
                end
            end
            if (rst) begin
                exp_q.delete();
                part_sum = 0;
                part_n   = 0;
            end else begin
                if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (in_valid && in_ready) begin
                    part_sum += lane_sum(partial_mul_vec);
                    part_n++;
                    if (part_n == TILES) begin
                        exp_q.push_back(wrap_acc(part_sum));
                        part_sum = 0;
                        part_n   = 0;
                    end
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (t_collect && t_out_valid) begin
            t_vals.push_back(longint'(t_out_data));
            t_cycs.push_back(cyc);
        end
    end

    task automatic send_beat(input logic [W-1:0] v);
        int guard = 0;
        in_valid = 1'b1;
        partial_mul_vec = v;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                check(1'b0, "send_timeout", guard, 200);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input longint expv, input string nm);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(out_valid === 1'b1, {nm, "_valid"}, out_valid, 1);
        check(longint'(out_data) == expv, nm, out_data, expv);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check(out_valid === 1'b0, "reset_out_valid", out_valid, 0);
        check(out_data === '0, "reset_out_data", out_data, 0);
        check(out_sat === 1'b0, "reset_out_sat", out_sat, 0);
        check(in_ready === 1'b1, "reset_in_ready", in_ready, 1);
        check(busy === 1'b0, "reset_busy", busy, 0);
        @(posedge clk);
        #1;

        // All lanes +1: 64, two edges after the last beat.
        for (int k = 0; k < TILES; k++) begin
            send_beat(rep(1));
            if (k == 2) begin
                @(negedge clk);
                check(busy === 1'b1, "t1_busy_mid", busy, 1);
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check(out_valid === 1'b0, "t1_not_early", out_valid, 0);
        check(busy === 1'b1, "t1_busy_s1", busy, 1);
        @(negedge clk);
        check(out_valid === 1'b1, "t1_latency", out_valid, 1);
        check(longint'(out_data) == 64, "t1_data", out_data, 64);
        check(busy === 1'b0, "t1_busy_fall", busy, 0);
        @(negedge clk);
        check(out_valid === 1'b0, "t1_valid_clear", out_valid, 0);
        @(posedge clk);
        #1;

        // Most negative lanes: no wrap at 24 bits.
        for (int k = 0; k < TILES; k++) send_beat(rep(-32768));
        wait_result(-2097152, "t2_min");
        check(out_sat === 1'b0, "t2_sat", out_sat, 0);
        @(posedge clk);
        #1;

        // Hold result 1 for 5 cycles while beats keep coming.
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 16; k++) send_beat(rep(k));
            end
            begin
                wait_result(288, "t3_r1");
                for (int j = 0; j < 5; j++) begin
                    check(in_ready === 1'b0, "t3_in_ready_stall", in_ready, 0);
                    check(longint'(out_data) == 288, "t3_hold", out_data, 288);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                wait_result(800, "t3_r2");
            end
        join
        @(posedge clk);
        #1;

        // Reset after 3 partial beats discards them.
        for (int k = 0; k < 3; k++) send_beat(rep(5));
        @(negedge clk);
        check(busy === 1'b1, "t4_busy_partial", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check(busy === 1'b0, "t4_busy_after_rst", busy, 0);
        check(out_valid === 1'b0, "t4_valid_after_rst", out_valid, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < TILES; k++) send_beat(rep(2));
        wait_result(128, "t4_fresh");
        @(posedge clk);
        #1;

        // Mixed-sign lanes scaled per beat.
        for (int k = 0; k < TILES; k++) send_beat(mix(k));
        wait_result(-144, "t5_mix");
        @(posedge clk);
        #1;

        // Three results with irregular downstream readiness; model-checked only.
        fork
            begin
                for (int k = 0; k < 3 * TILES; k++) send_beat(scatter(k));
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    out_ready = (c % 3) != 0;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);

        // ACC_BW=18: wraps to -64, or clamps at 131071 with the flag when saturating.
        w_valid = 1'b1;
        w_vec = rep(32767);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check(w_in_ready === 1'b1, "w18_in_ready", w_in_ready, 1);
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
        begin
            int n = 0;
            @(negedge clk);
            while (!w_out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check(w_out_valid === 1'b1, "w18_valid", w_out_valid, 1);
`ifdef VEC_MUL_ACCUM_SATURATE_EN
        check(longint'(w_out_data) == 131071, "w18_sat_data", w_out_data, 131071);
        check(w_out_sat === 1'b1, "w18_sat_flag", w_out_sat, 1);
`else
        check(longint'(w_out_data) == -64, "w18_wrap_data", w_out_data, -64);
        check(w_out_sat === 1'b0, "w18_wrap_flag", w_out_sat, 0);
`endif
        @(posedge clk);
        #1;

        // TILES=1: alternating +3/-7 lanes stream one result per cycle.
        t_collect = 1'b1;
        t_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            t_vec = rep((k % 2) ? -7 : 3);
            @(posedge clk);
            #1;
        end
        t_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        t_collect = 1'b0;
        check(t_vals.size() == 6, "t1_count", t_vals.size(), 6);
        for (int k = 0; k < t_vals.size() && k < 6; k++) begin
            check(t_vals[k] == ((k % 2) ? -56 : 24), "t1_value", t_vals[k], (k % 2) ? -56 : 24);
            if (k > 0) check(t_cycs[k] == t_cycs[k-1] + 1, "t1_no_bubble", t_cycs[k] - t_cycs[k-1], 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
